// File: rtl/ifft8_core.sv
// rtl/ifft8_core.sv - iterative 8-point radix-2 DIT inverse FFT, one butterfly per clock
// Define IFFT8_SCALE_EN for a per-stage 1/2 shift (normalized IFFT); default build is unscaled.
module ifft8_core #(
  parameter int DW = 16,
  parameter int TW = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [8*DW-1:0] re_in,
  input  logic [8*DW-1:0] im_in,
  output logic [8*DW-1:0] re_out,
  output logic [8*DW-1:0] im_out,
  output logic            busy,
  output logic            done
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_OUT} state_t;

  state_t                r_state;
  logic signed [DW-1:0]  r_re [8];
  logic signed [DW-1:0]  r_im [8];
  logic [1:0]            r_stage;
  logic [1:0]            r_bf;

  logic [2:0]            w_top;
  logic [2:0]            w_bot;
  logic [1:0]            w_tw;
  logic signed [TW-1:0]  w_wr;
  logic signed [TW-1:0]  w_wi;
  logic signed [31:0]    w_p_rr, w_p_ii, w_p_ri, w_p_ir;
  logic signed [32:0]    w_sum_re, w_sum_im;
  logic signed [17:0]    w_t_re, w_t_im;
  logic signed [18:0]    w_y0_re, w_y0_im, w_y1_re, w_y1_im;
  logic signed [18:0]    w_s0_re, w_s0_im, w_s1_re, w_s1_im;

  function automatic logic [2:0] bitrev3(input logic [2:0] k);
    return {k[0], k[1], k[2]};
  endfunction

  function automatic logic signed [DW-1:0] sat19(input logic signed [18:0] v);
    if (v > 19'sd32767)       return 16'sh7fff;
    else if (v < -19'sd32768) return 16'sh8000;
    else                      return v[15:0];
  endfunction

  // Butterfly addressing: span doubles each stage, twiddle stride halves
  always_comb begin
    w_top = 3'd0;
    w_bot = 3'd0;
    w_tw  = 2'd0;
    case (r_stage)
      2'd0: begin
        w_top = {r_bf, 1'b0};
        w_bot = {r_bf, 1'b1};
        w_tw  = 2'd0;
      end
      2'd1: begin
        w_top = {r_bf[1], 1'b0, r_bf[0]};
        w_bot = {r_bf[1], 1'b1, r_bf[0]};
        w_tw  = {r_bf[0], 1'b0};
      end
      default: begin
        w_top = {1'b0, r_bf};
        w_bot = {1'b1, r_bf};
        w_tw  = r_bf;
      end
    endcase
  end

  // Conjugated twiddles e^{+j2pik/8}, Q1.14
  always_comb begin
    w_wr = 16'sd16384;
    w_wi = 16'sd0;
    case (w_tw)
      2'd0: begin w_wr = 16'sd16384;  w_wi = 16'sd0;     end
      2'd1: begin w_wr = 16'sd11585;  w_wi = 16'sd11585; end
      2'd2: begin w_wr = 16'sd0;      w_wi = 16'sd16384; end
      default: begin w_wr = -16'sd11585; w_wi = 16'sd11585; end
    endcase
  end

  assign w_p_rr   = 32'(r_re[w_bot]) * 32'(w_wr);
  assign w_p_ii   = 32'(r_im[w_bot]) * 32'(w_wi);
  assign w_p_ri   = 32'(r_re[w_bot]) * 32'(w_wi);
  assign w_p_ir   = 32'(r_im[w_bot]) * 32'(w_wr);
  assign w_sum_re = 33'(w_p_rr) - 33'(w_p_ii) + 33'sd8192;
  assign w_sum_im = 33'(w_p_ri) + 33'(w_p_ir) + 33'sd8192;
  assign w_t_re   = 18'(w_sum_re >>> 14);
  assign w_t_im   = 18'(w_sum_im >>> 14);

  assign w_y0_re  = 19'(r_re[w_top]) + 19'(w_t_re);
  assign w_y0_im  = 19'(r_im[w_top]) + 19'(w_t_im);
  assign w_y1_re  = 19'(r_re[w_top]) - 19'(w_t_re);
  assign w_y1_im  = 19'(r_im[w_top]) - 19'(w_t_im);

`ifdef IFFT8_SCALE_EN
  assign w_s0_re = w_y0_re >>> 1;
  assign w_s0_im = w_y0_im >>> 1;
  assign w_s1_re = w_y1_re >>> 1;
  assign w_s1_im = w_y1_im >>> 1;
`else
  assign w_s0_re = w_y0_re;
  assign w_s0_im = w_y0_im;
  assign w_s1_re = w_y1_re;
  assign w_s1_im = w_y1_im;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_stage <= 2'd0;
      r_bf    <= 2'd0;
      busy    <= 1'b0;
      done    <= 1'b0;
      re_out  <= '0;
      im_out  <= '0;
      for (int i = 0; i < 8; i++) begin
        r_re[i] <= '0;
        r_im[i] <= '0;
      end
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            for (int k = 0; k < 8; k++) begin
              r_re[bitrev3(3'(k))] <= re_in[DW*k +: DW];
              r_im[bitrev3(3'(k))] <= im_in[DW*k +: DW];
            end
            r_stage <= 2'd0;
            r_bf    <= 2'd0;
            busy    <= 1'b1;
            r_state <= S_CALC;
          end
        end
        S_CALC: begin
          r_re[w_top] <= sat19(w_s0_re);
          r_im[w_top] <= sat19(w_s0_im);
          r_re[w_bot] <= sat19(w_s1_re);
          r_im[w_bot] <= sat19(w_s1_im);
          r_bf        <= r_bf + 2'd1;
          if (r_bf == 2'd3) begin
            if (r_stage == 2'd2) begin
              r_stage <= 2'd0;
              r_state <= S_OUT;
            end else begin
              r_stage <= r_stage + 2'd1;
            end
          end
        end
        S_OUT: begin
          for (int k = 0; k < 8; k++) begin
            re_out[DW*k +: DW] <= r_re[k];
            im_out[DW*k +: DW] <= r_im[k];
          end
          done    <= 1'b1;
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ifft8_core.sv
// tb/tb_ifft8_core.sv - self-checking bench for ifft8_core against a staged integer IFFT model
module tb_ifft8_core;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [127:0] re_in, im_in;
  logic [127:0] re_out, im_out;
  logic         busy, done;

  always #5 clk = ~clk;

  ifft8_core #(.DW(16), .TW(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .re_in(re_in), .im_in(im_in),
    .re_out(re_out), .im_out(im_out),
    .busy(busy), .done(done)
  );

`ifdef IFFT8_SCALE_EN
  localparam int AMP = 8000;
`else
  localparam int AMP = 1000;
`endif

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;
  logic [127:0] e_re, e_im;
  int cyc, lat, err;
  logic got, busy_bad;

  function automatic int lane(input logic [127:0] v, input int k);
    return int'($signed(v[16*k +: 16]));
  endfunction

  function automatic int sat16(input int v);
    if (v > 32767)  return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  // Reference: textbook DIT on bit-reversed input, grouped by butterfly span
  task automatic model(input logic [127:0] xr, input logic [127:0] xi);
    int ar[8];
    int ai[8];
    int wr[4] = '{16384, 11585, 0, -11585};
    int wi[4] = '{0, 11585, 16384, 11585};
    int h, tp, bt, kk, tr, ti, y0r, y0i, y1r, y1i, j;
    for (int k = 0; k < 8; k++) begin
      j = ((k & 1) << 2) | (k & 2) | ((k >> 2) & 1);
      ar[j] = lane(xr, k);
      ai[j] = lane(xi, k);
    end
    for (int s = 0; s < 3; s++) begin
      h = 1 << s;
      for (int g = 0; g < 8; g += 2 * h) begin
        for (int m = 0; m < h; m++) begin
          tp = g + m;
          bt = tp + h;
          kk = m * (4 >> s);
          tr = (ar[bt] * wr[kk] - ai[bt] * wi[kk] + 8192) >>> 14;
          ti = (ar[bt] * wi[kk] + ai[bt] * wr[kk] + 8192) >>> 14;
          y0r = ar[tp] + tr;  y0i = ai[tp] + ti;
          y1r = ar[tp] - tr;  y1i = ai[tp] - ti;
`ifdef IFFT8_SCALE_EN
          y0r = y0r >>> 1;  y0i = y0i >>> 1;
          y1r = y1r >>> 1;  y1i = y1i >>> 1;
`endif
          ar[tp] = sat16(y0r);  ai[tp] = sat16(y0i);
          ar[bt] = sat16(y1r);  ai[bt] = sat16(y1i);
        end
      end
    end
    for (int k = 0; k < 8; k++) begin
      e_re[16*k +: 16] = 16'(ar[k]);
      e_im[16*k +: 16] = 16'(ai[k]);
    end
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_tol(input string tag, input int obs, input int exp, input int tol);
    n_total++;
    assert ((obs - exp) <= tol && (exp - obs) <= tol) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d tol=%0d", tag, obs, exp, tol);
    end
  endtask

  task automatic set_lane(input int k, input int r, input int i);
    re_in[16*k +: 16] = 16'(r);
    im_in[16*k +: 16] = 16'(i);
  endtask

  task automatic run_xform(input string tag);
    model(re_in, im_in);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk({tag, "_busy_rise"}, 128'(busy), 128'(1));
    got = 1'b0;
    lat = 0;
    for (int c = 1; c <= 20 && !got; c++) begin
      @(posedge clk); #1;
      lat = c;
      if (done) got = 1'b1;
    end
    chk({tag, "_latency"}, 128'(lat), 128'(13));
    chk({tag, "_busy_fall"}, 128'(busy), 128'(0));
    chk({tag, "_re"}, re_out, e_re);
    chk({tag, "_im"}, im_out, e_im);
    @(posedge clk); #1;
    chk({tag, "_done_fall"}, 128'(done), 128'(0));
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    re_in = '0;
    im_in = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_re", re_out, 128'd0);
    chk("reset_im", im_out, 128'd0);
    chk("reset_busy_done", 128'({busy, done}), 128'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Impulse: every sample equals X0 scaled to 1000
    re_in = '0; im_in = '0;
    set_lane(0, AMP, 0);
    run_xform("impulse");
    chk("impulse_const_re", re_out, {8{16'd1000}});
    chk("impulse_const_im", im_out, 128'd0);

    // DC: energy collapses into x[0]
    for (int k = 0; k < 8; k++) set_lane(k, AMP, 0);
    run_xform("dc");
    chk_tol("dc_x0_re", lane(re_out, 0), 8000, 1);
    chk_tol("dc_x0_im", lane(im_out, 0), 0, 1);
    err = 0;
    for (int k = 1; k < 8; k++) begin
      if (lane(re_out, k) > err)  err = lane(re_out, k);
      if (-lane(re_out, k) > err) err = -lane(re_out, k);
      if (lane(im_out, k) > err)  err = lane(im_out, k);
      if (-lane(im_out, k) > err) err = -lane(im_out, k);
    end
    chk_tol("dc_rest_maxabs", err, 0, 1);

    // Single tone in bin 1 rotates forward
    re_in = '0; im_in = '0;
    set_lane(1, AMP, 0);
    run_xform("tone");
    chk_tol("tone_x0_re", lane(re_out, 0), 1000, 2);
    chk_tol("tone_x0_im", lane(im_out, 0), 0, 2);
    chk_tol("tone_x1_re", lane(re_out, 1), 707, 2);
    chk_tol("tone_x1_im", lane(im_out, 1), 707, 2);
    chk_tol("tone_x2_re", lane(re_out, 2), 0, 2);
    chk_tol("tone_x2_im", lane(im_out, 2), 1000, 2);
    chk_tol("tone_x5_re", lane(re_out, 5), -707, 2);
    chk_tol("tone_x5_im", lane(im_out, 5), -707, 2);

    // Full-scale DC must clip, not wrap
    for (int k = 0; k < 8; k++) set_lane(k, 32767, 0);
    run_xform("sat");
    chk("sat_x0_re", 128'(lane(re_out, 0)), 128'(32767));
    chk("sat_x0_im", 128'(lane(im_out, 0)), 128'(0));

    for (int t = 0; t < 6; t++) begin
      re_in = {$urandom, $urandom, $urandom, $urandom};
      im_in = {$urandom, $urandom, $urandom, $urandom};
      run_xform($sformatf("rand%0d", t));
    end

    // Streaming with start held high
    re_in = {$urandom, $urandom, $urandom, $urandom};
    im_in = {$urandom, $urandom, $urandom, $urandom};
    model(re_in, im_in);
    start = 1'b1;
    @(posedge clk); #1;
    cyc = 0;
    busy_bad = 1'b0;
    for (int it = 0; it < 4; it++) begin
      got = 1'b0;
      for (int c = 0; c < 20 && !got; c++) begin
        @(posedge clk); #1;
        cyc++;
        if (done) got = 1'b1;
        else if (!busy) busy_bad = 1'b1;
      end
      if (busy) busy_bad = 1'b1;
      chk($sformatf("stream%0d_time", it), 128'(cyc), 128'(13 + 14 * it));
      chk($sformatf("stream%0d_re", it), re_out, e_re);
      chk($sformatf("stream%0d_im", it), im_out, e_im);
      if (it == 3) begin
        start = 1'b0;
      end else begin
        re_in = {$urandom, $urandom, $urandom, $urandom};
        im_in = {$urandom, $urandom, $urandom, $urandom};
        model(re_in, im_in);
      end
    end
    chk("stream_busy_pattern", 128'(busy_bad), 128'(0));
    @(posedge clk); #1;

    // Reset abort five cycles into a transform
    re_in = {$urandom, $urandom, $urandom, $urandom};
    im_in = {$urandom, $urandom, $urandom, $urandom};
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 128'(busy), 128'(0));
    chk("abort_re", re_out, 128'd0);
    chk("abort_im", im_out, 128'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    got = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (done || busy) got = 1'b1;
    end
    chk("abort_no_done", 128'(got), 128'(0));
    chk("abort_outputs_held0", {re_out ^ im_out}, 128'd0);
    re_in = {$urandom, $urandom, $urandom, $urandom};
    im_in = {$urandom, $urandom, $urandom, $urandom};
    run_xform("after_abort");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
